// File: rtl/bus_decoder_if.sv
// CPU data-port / slave-side signal bundle for bus_decoder.
// slave modport: the decoder's view. master modport: CPU plus slaves around it.
interface bus_decoder_if #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32
) ();
  logic                         cpud_request;
  logic [31:0]                  cpud_addr;
  logic [DATA_W-1:0]            cpud_rdata;
  logic                         cpud_ack;
  logic                         cpud_error;
  logic [NUM_SLAVES-1:0]        slv_req;
  logic [NUM_SLAVES-1:0]        slv_ack;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;

  modport slave (
    input  cpud_request, cpud_addr, slv_ack, slv_rdata,
    output cpud_rdata, cpud_ack, cpud_error, slv_req
  );

  modport master (
    output cpud_request, cpud_addr, slv_ack, slv_rdata,
    input  cpud_rdata, cpud_ack, cpud_error, slv_req
  );
endinterface

// File: rtl/bus_decoder.sv
// CPU data-bus decoder: routes one outstanding request to the lowest-index
// slave whose base/mask matches, and returns that slave's ack/read data.
// Unmapped addresses end with an error ack. Optional BUSY timeout enabled by
// defining BUS_DECODER_TIMEOUT_EN.
module bus_decoder #(
  parameter int                     NUM_SLAVES     = 3,
  parameter int                     DATA_W         = 32,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE   = {32'hFFFF0000, 32'hE0000000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK   = {32'hFFFF0000, 32'hFFFF0000, 32'hFC000000},
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          resetn,
  bus_decoder_if.slave  bus
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("bus_decoder: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_decoder: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] hit_idx;
  logic             hit;
  logic             accept;
  logic             sel_ack;

  // Address decode: scan downwards so the lowest matching index is left last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
      if ((bus.cpud_addr & SLAVE_MASK[32*(i-1) +: 32]) == SLAVE_BASE[32*(i-1) +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i-1);
      end
    end
  end

  assign accept  = (state == ST_IDLE) && bus.cpud_request && hit;
  assign sel_ack = bus.slv_ack[sel];

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;
  logic        timeout;

  // Count BUSY cycles without the selected slave's ack; cleared on accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (state == ST_BUSY && !sel_ack)
      cnt <= cnt + 16'd1;
  end

  // Limit is reached in the BUSY cycle whose increment would hit TIMEOUT_CYCLES.
  assign timeout = (cnt == TO_LAST);
`endif

  // State and selected-slave registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        sel <= hit_idx;
    end
  end

  // Next-state logic; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.cpud_request) state_nxt = hit ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (sel_ack)
          state_nxt = ST_IDLE;
`ifdef BUS_DECODER_TIMEOUT_EN
        else if (timeout)
          state_nxt = ST_ERR;
`endif
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: same-cycle request fan-out and same-cycle completion return.
  always_comb begin
    bus.slv_req    = '0;
    bus.cpud_ack   = 1'b0;
    bus.cpud_error = 1'b0;
    bus.cpud_rdata = '0;
    if (accept && resetn)
      bus.slv_req = NUM_SLAVES'(1) << hit_idx;
    case (state)
      ST_BUSY: begin
        bus.cpud_ack = sel_ack;
        if (sel_ack)
          bus.cpud_rdata = bus.slv_rdata[DATA_W*int'(sel) +: DATA_W];
      end
      ST_ERR: begin
        bus.cpud_ack   = 1'b1;
        bus.cpud_error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed self-checking bench for bus_decoder (default slave map, TIMEOUT_CYCLES=4).
module tb_bus_decoder;

  logic clock;
  logic resetn;
  int   tests;
  int   failed;

  bus_decoder_if #(.NUM_SLAVES(3), .DATA_W(32)) bus ();

  bus_decoder #(
    .NUM_SLAVES     (3),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_rdata(input int idx, input logic [31:0] v);
    bus.slv_rdata[32*idx +: 32] = v;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    resetn = 1'b0;
    bus.cpud_request = 1'b1;
    bus.cpud_addr    = 32'h0000_1000;
    bus.slv_ack      = '0;
    bus.slv_rdata    = '0;
    #12;
    chk("rst_slv_req_gated", 32'(bus.slv_req), 32'h0);
    chk("rst_ack",           32'(bus.cpud_ack), 32'h0);
    chk("rst_err",           32'(bus.cpud_error), 32'h0);
    chk("rst_rdata",         bus.cpud_rdata, 32'h0);
    bus.cpud_request = 1'b0;
    #5 resetn = 1'b1;

    // Slave 0 read, ack two cycles after request.
    cyc();
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h0000_1000;
    settle();
    chk("t1_slv_req", 32'(bus.slv_req), 32'h1);
    chk("t1_ack_req_cycle", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.cpud_request = 1'b0;
    settle();
    chk("t1_busy_noack", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.slv_ack = 3'b001; set_rdata(0, 32'h1234_5678);
    settle();
    chk("t1_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t1_rdata", bus.cpud_rdata, 32'h1234_5678);
    chk("t1_err", 32'(bus.cpud_error), 32'h0);
    cyc();
    bus.slv_ack = '0;
    settle();
    chk("t1_idle_ack", 32'(bus.cpud_ack), 32'h0);
    chk("t1_idle_rdata", bus.cpud_rdata, 32'h0);

    // Slave 1, ack in request cycle and stray slave-2 ack both ignored.
    cyc();
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'hE000_0010;
    bus.slv_ack = 3'b010; set_rdata(1, 32'h0000_0011);
    settle();
    chk("t2_slv_req", 32'(bus.slv_req), 32'h2);
    chk("t2_ack_in_req_cycle", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.cpud_request = 1'b0;
    bus.slv_ack = 3'b100; set_rdata(2, 32'hDEAD_BEEF);
    settle();
    chk("t2_stray_ack", 32'(bus.cpud_ack), 32'h0);
    chk("t2_stray_rdata", bus.cpud_rdata, 32'h0);
    cyc();
    bus.slv_ack = 3'b010; set_rdata(1, 32'h0000_00A5);
    settle();
    chk("t2_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t2_rdata", bus.cpud_rdata, 32'h0000_00A5);

    // Back-to-back: unmapped request right after the ack cycle.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h4000_0000;
    set_rdata(0, 32'h5A5A_5A5A);
    settle();
    chk("t3_slv_req_none", 32'(bus.slv_req), 32'h0);
    chk("t3_ack_req_cycle", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.cpud_request = 1'b0;
    settle();
    chk("t3_err_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t3_err_flag", 32'(bus.cpud_error), 32'h1);
    chk("t3_err_rdata", bus.cpud_rdata, 32'h0);

    // Just-unmapped boundary: 0x04000000 is outside slave 0's window.
    cyc();
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h0400_0000;
    settle();
    chk("t3b_edge_unmapped_req", 32'(bus.slv_req), 32'h0);
    cyc();
    bus.cpud_request = 1'b0;
    settle();
    chk("t3b_edge_err", 32'(bus.cpud_error), 32'h1);

    // Top of slave 0's window, accepted back-to-back after the error ack.
    cyc();
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h03FF_FFFC;
    settle();
    chk("t3c_edge_mapped_req", 32'(bus.slv_req), 32'h1);
    cyc();
    bus.cpud_request = 1'b0;
    bus.slv_ack = 3'b001; set_rdata(0, 32'h0000_0055);
    settle();
    chk("t3c_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t3c_rdata", bus.cpud_rdata, 32'h0000_0055);

    // Request while BUSY is dropped; original transaction completes.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'hE000_0000;
    settle();
    chk("t4_slv_req", 32'(bus.slv_req), 32'h2);
    cyc();
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h0000_0000;
    settle();
    chk("t4_dropped_req", 32'(bus.slv_req), 32'h0);
    chk("t4_dropped_ack", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.cpud_request = 1'b0;
    bus.slv_ack = 3'b010; set_rdata(1, 32'h0000_0077);
    settle();
    chk("t4_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t4_rdata", bus.cpud_rdata, 32'h0000_0077);
    chk("t4_err", 32'(bus.cpud_error), 32'h0);

`ifdef BUS_DECODER_TIMEOUT_EN
    // Timeout: error ack 5 cycles after request, late ack ignored.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'hFFFF_0004;
    settle();
    chk("t5_slv_req", 32'(bus.slv_req), 32'h4);
    cyc();
    bus.cpud_request = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("t5_busy_c%0d", c), 32'(bus.cpud_ack), 32'h0);
      cyc();
    end
    settle();
    chk("t5_to_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t5_to_err", 32'(bus.cpud_error), 32'h1);
    chk("t5_to_rdata", bus.cpud_rdata, 32'h0);
    cyc();
    bus.slv_ack = 3'b100; set_rdata(2, 32'h0000_0099);
    settle();
    chk("t5_late_ack", 32'(bus.cpud_ack), 32'h0);

    // Ack in the limit cycle wins over the timeout.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'hFFFF_0004;
    cyc();
    bus.cpud_request = 1'b0;
    cyc();
    cyc();
    cyc();
    bus.slv_ack = 3'b100;
    settle();
    chk("t5b_limit_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t5b_limit_err", 32'(bus.cpud_error), 32'h0);
    chk("t5b_limit_rdata", bus.cpud_rdata, 32'h0000_0099);
    cyc();
    bus.slv_ack = '0;
    settle();
    chk("t5b_after", 32'(bus.cpud_ack), 32'h0);
`else
    // Without timeout, BUSY waits indefinitely for the slave.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'hFFFF_0004;
    settle();
    chk("t5_slv_req", 32'(bus.slv_req), 32'h4);
    cyc();
    bus.cpud_request = 1'b0;
    for (int c = 1; c <= 20; c++) cyc();
    settle();
    chk("t5_no_timeout_ack", 32'(bus.cpud_ack), 32'h0);
    chk("t5_no_timeout_err", 32'(bus.cpud_error), 32'h0);
    cyc();
    bus.slv_ack = 3'b100; set_rdata(2, 32'h0000_0099);
    settle();
    chk("t5_slow_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t5_slow_rdata", bus.cpud_rdata, 32'h0000_0099);
    chk("t5_slow_err", 32'(bus.cpud_error), 32'h0);
`endif

    // Reset while BUSY: outputs drop at once, pending ack ignored afterwards.
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h0000_1000;
    cyc();
    bus.cpud_request = 1'b0;
    bus.slv_ack = 3'b001; set_rdata(0, 32'h0000_00EE);
    settle();
    chk("t6_pre_reset_ack", 32'(bus.cpud_ack), 32'h1);
    resetn = 1'b0;
    #1;
    chk("t6_reset_ack", 32'(bus.cpud_ack), 32'h0);
    chk("t6_reset_rdata", bus.cpud_rdata, 32'h0);
    chk("t6_reset_err", 32'(bus.cpud_error), 32'h0);
    chk("t6_reset_req", 32'(bus.slv_req), 32'h0);
    #1 resetn = 1'b1;
    cyc();
    settle();
    chk("t6_pending_ack_ignored", 32'(bus.cpud_ack), 32'h0);
    cyc();
    bus.slv_ack = '0;
    bus.cpud_request = 1'b1; bus.cpud_addr = 32'h0000_1000;
    settle();
    chk("t6_fresh_req", 32'(bus.slv_req), 32'h1);
    cyc();
    bus.cpud_request = 1'b0;
    bus.slv_ack = 3'b001; set_rdata(0, 32'h0000_CAFE);
    settle();
    chk("t6_fresh_ack", 32'(bus.cpud_ack), 32'h1);
    chk("t6_fresh_rdata", bus.cpud_rdata, 32'h0000_CAFE);
    cyc();
    bus.slv_ack = '0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised CPU data-bus decoder: routes each single-cycle CPU data request to one of `NUM_SLAVES` targets selected by base/mask match. It tracks the one outstanding transaction and returns only the selected slave's read data. Unmapped addresses and, optionally, unresponsive slaves terminate with an error acknowledge. Sits between the CPU data port and the data cache, instruction RAM, hardware registers and future peripherals.

## Interface
- `NUM_SLAVES`, 3: number of targets; 1..16.
- `DATA_W`, 32: read data width.
- `SLAVE_BASE`, {32'hFFFF0000, 32'hE0000000, 32'h00000000}: packed `NUM_SLAVES*32`; slave i base in bits [32i+31:32i].
- `SLAVE_MASK`, {32'hFFFF0000, 32'hFFFF0000, 32'hFC000000}: packed `NUM_SLAVES*32`; slave i mask in the same bit positions.
- `TIMEOUT_CYCLES`, 255: BUSY cycles before error termination; 1..65535.

- `clock` in 1: sole clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous assert, active low.
- `cpud_request` in 1: single-cycle request pulse.
- `cpud_addr` in 32: request address; valid while `cpud_request` is high.
- `cpud_rdata` out DATA_W: read data; valid only while `cpud_ack` is high, otherwise 0.
- `cpud_ack` out 1: single-cycle transaction completion.
- `cpud_error` out 1: qualifies `cpud_ack`; 1 = unmapped address or timeout.
- `slv_req` out NUM_SLAVES: one-hot request pulse to slave i.
- `slv_ack` in NUM_SLAVES: slave i completion pulse.
- `slv_rdata` in NUM_SLAVES*DATA_W: slave i read data, in bits [DATA_W*i +: DATA_W].

## Operation
- Decode: slave i matches when `(cpud_addr & mask_i) == base_i`. The lowest matching index wins, so overlaps are legal.
- States:
  - IDLE: accepts requests.
  - BUSY: waiting for the selected slave.
  - ERR: one cycle, issuing the error ack.
- IDLE with `cpud_request=1`:
  - On a match: `slv_req[i]=1` combinationally in the same cycle; latch `sel=i`; clear the timeout counter; go to BUSY.
  - On no match: no `slv_req`; go to ERR.
- BUSY:
  - `cpud_ack = slv_ack[sel]` and `cpud_rdata = slv_rdata[sel]`, both combinational.
  - On `slv_ack[sel]`, go to IDLE.
  - `slv_ack` from non-selected slaves is ignored and does not appear on `cpud_rdata`.
- ERR: `cpud_ack=1`, `cpud_error=1`, `cpud_rdata=0`; go to IDLE.
- `cpud_request` while BUSY or ERR is a protocol violation. It is dropped: no `slv_req`, no ack, no state change.
- `slv_ack[i]` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `sel=0`, counter 0. `slv_req`, `cpud_ack`, `cpud_error` and `cpud_rdata` are all 0. `slv_req` is gated low while `resetn=0`.
- The decoder adds zero cycles on the request path: `slv_req` is in the same cycle as `cpud_request`.
- The decoder adds zero cycles on the completion path: `cpud_ack` is in the same cycle as `slv_ack[sel]`.
- The earliest ack accepted is in the cycle after the request; a slave ack in the request cycle is ignored.
- Unmapped address: `cpud_ack`+`cpud_error` exactly 1 cycle after the request.
- Back-to-back: a new request is accepted in the cycle after `cpud_ack`; the cycle of the ack itself is still BUSY or ERR.
- Timeout:
  - The counter increments each BUSY cycle without `slv_ack[sel]`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM moves to ERR. The error ack occurs `TIMEOUT_CYCLES+1` cycles after the request.
  - If `slv_ack[sel]` arrives in the same cycle the counter reaches its limit, the slave ack wins and no error is issued.
  - A late slave ack after a timeout is ignored.
- Reset mid-transaction: immediate return to IDLE; any pending slave ack arriving after release is ignored.

## Configuration
- `BUS_DECODER_TIMEOUT_EN` defined: timeout counter and the BUSY→ERR timeout transition are present.
- Undefined:
  - No counter is implemented and `TIMEOUT_CYCLES` is unused.
  - BUSY waits indefinitely for `slv_ack[sel]`.
  - `cpud_error` is raised only for unmapped addresses.

## Test plan
- Request to 0x00001000; slave 0 acks 2 cycles later with 0x12345678:
  - `slv_req=3'b001` in the request cycle.
  - `cpud_ack=1`, `cpud_rdata=0x12345678`, `cpud_error=0` on the ack cycle.
- Request to 0xE0000010 while slave 2 drives `slv_rdata=0xDEADBEEF` and pulses a stray `slv_ack[2]`; slave 1 then acks with 0xA5:
  - The stray ack is ignored.
  - `cpud_rdata=0xA5` only.
- Request to 0x40000000: no `slv_req`; next cycle `cpud_ack=1`, `cpud_error=1`, `cpud_rdata=0`.
- With `BUS_DECODER_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, request to 0xFFFF0004 with no slave ack:
  - Error ack 5 cycles after the request.
  - A late `slv_ack[2]` produces no `cpud_ack`.
- Second `cpud_request` while BUSY: no `slv_req` pulse; the original transaction completes normally.
- Assert `resetn` low while BUSY: all outputs 0 immediately; after release, a pending slave ack is ignored and a fresh request to slave 0 succeeds.
